// File: rtl/quad_pkg.sv
// Shared types, limits and saturating step helper for the quadrature delta counter.
package quad_pkg;

    typedef logic signed [8:0] delta_t;

    localparam delta_t DELTA_MAX = 9'sd255;
    localparam delta_t DELTA_MIN = 9'sh100;

    typedef enum logic {StEmpty, StFull} out_state_e;

    // Apply at most one step, clamping at the 9-bit signed limits.
    function automatic delta_t sat_step(delta_t acc, logic up, logic dn);
        if (up && (acc != DELTA_MAX)) return acc + 9'sd1;
        if (dn && (acc != DELTA_MIN)) return acc - 9'sd1;
        return acc;
    endfunction

endpackage

// File: rtl/quad_step_decoder.sv
// Two-flop synchronizer plus Gray-code transition decode for a quadrature encoder.
// With QUAD_ERR_EN defined, also flags double-bit (illegal) transitions.
module quad_step_decoder (
    input  logic clk,
    input  logic rst_n,
    input  logic enc_a,
    input  logic enc_b,
    output logic step_up,
    output logic step_dn
`ifdef QUAD_ERR_EN
    ,
    output logic step_err
`endif
);

    logic [1:0] sync1_q;
    logic [1:0] sync2_q;
    logic [1:0] prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
            prev_q  <= 2'b00;
        end else begin
            sync1_q <= {enc_a, enc_b};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Forward order is {a,b}: 00 -> 01 -> 11 -> 10 -> 00.
    always_comb begin
        step_up = 1'b0;
        step_dn = 1'b0;
        case ({prev_q, sync2_q})
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: step_up = 1'b1;
            4'b01_00, 4'b11_01, 4'b10_11, 4'b00_10: step_dn = 1'b1;
            default: ;
        endcase
    end

`ifdef QUAD_ERR_EN
    assign step_err = ((prev_q ^ sync2_q) == 2'b11);
`endif

endmodule

// File: rtl/quad_delta_counter.sv
// Per-window quadrature step counter with a one-entry valid/ready result buffer.
// Optional sticky enc_err output is enabled by defining QUAD_ERR_EN.
module quad_delta_counter
    import quad_pkg::*;
#(
    parameter int unsigned WINDOW_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enc_a,
    input  logic       enc_b,
    input  logic       en,
    output logic [8:0] delta,
    output logic       delta_valid,
    input  logic       delta_ready,
    output logic       overrun
`ifdef QUAD_ERR_EN
    ,
    output logic       enc_err
`endif
);

    localparam int unsigned CW = $clog2(WINDOW_CYCLES);
    localparam logic [CW-1:0] LastCycle = CW'(WINDOW_CYCLES - 1);

    logic          step_up;
    logic          step_dn;
    logic [CW-1:0] win_cnt_q;
    delta_t        acc_q;
    delta_t        acc_next;
    logic          close;
    logic          handshake;
    out_state_e    state_q;
    delta_t        delta_q;
    logic          overrun_q;

`ifdef QUAD_ERR_EN
    logic step_err;
    logic enc_err_q;
`endif

    quad_step_decoder u_decoder (
        .clk     (clk),
        .rst_n   (rst_n),
        .enc_a   (enc_a),
        .enc_b   (enc_b),
        .step_up (step_up),
        .step_dn (step_dn)
`ifdef QUAD_ERR_EN
        ,
        .step_err(step_err)
`endif
    );

    always_comb begin
        acc_next  = sat_step(acc_q, step_up, step_dn);
        close     = en && (win_cnt_q == LastCycle);
        handshake = (state_q == StFull) && delta_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_cnt_q <= '0;
            acc_q     <= '0;
        end else if (!en) begin
            win_cnt_q <= '0;
            acc_q     <= '0;
        end else if (close) begin
            win_cnt_q <= '0;
            acc_q     <= '0;
        end else begin
            win_cnt_q <= win_cnt_q + CW'(1);
            acc_q     <= acc_next;
        end
    end

    // Result buffer: a close always loads; overrun only when an unconsumed value is lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StEmpty;
            delta_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            case (state_q)
                StEmpty: begin
                    if (close) begin
                        delta_q <= acc_next;
                        state_q <= StFull;
                    end
                end
                StFull: begin
                    if (close) begin
                        delta_q   <= acc_next;
                        overrun_q <= !handshake;
                    end else if (handshake) begin
                        state_q   <= StEmpty;
                        overrun_q <= 1'b0;
                    end
                end
                default: state_q <= StEmpty;
            endcase
        end
    end

    assign delta       = delta_q;
    assign delta_valid = (state_q == StFull);
    assign overrun     = overrun_q;

`ifdef QUAD_ERR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_err_q <= 1'b0;
        end else if (step_err) begin
            enc_err_q <= 1'b1;
        end
    end

    assign enc_err = enc_err_q;
`endif

endmodule

// File: tb/tb_quad_delta_counter.sv
// Directed self-checking bench for quad_delta_counter (W=100 main instance, W=512 for saturation).
module tb_quad_delta_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enc_a;
    logic       enc_b;
    logic       en;
    logic       en_sat;
    logic       delta_ready;
    logic       ready_sat;
    logic [8:0] delta;
    logic [8:0] delta_sat;
    logic       delta_valid;
    logic       valid_sat;
    logic       overrun;
    logic       overrun_sat;
`ifdef QUAD_ERR_EN
    logic       enc_err;
    logic       enc_err_sat;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int pos     = 0;

    logic [1:0] gray [4] = '{2'b00, 2'b01, 2'b11, 2'b10};

    always #5 clk = ~clk;

    quad_delta_counter #(.WINDOW_CYCLES(100)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .en         (en),
        .delta      (delta),
        .delta_valid(delta_valid),
        .delta_ready(delta_ready),
        .overrun    (overrun)
`ifdef QUAD_ERR_EN
        ,
        .enc_err    (enc_err)
`endif
    );

    quad_delta_counter #(.WINDOW_CYCLES(512)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .enc_a      (enc_a),
        .enc_b      (enc_b),
        .en         (en_sat),
        .delta      (delta_sat),
        .delta_valid(valid_sat),
        .delta_ready(ready_sat),
        .overrun    (overrun_sat)
`ifdef QUAD_ERR_EN
        ,
        .enc_err    (enc_err_sat)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive();
        {enc_a, enc_b} = gray[pos & 3];
    endtask

    task automatic step(input int n, input int dir);
        for (int i = 0; i < n; i++) begin
            pos += dir;
            drive();
            @(negedge clk);
        end
    endtask

    // Raise en, apply nf forward steps, stop on the close cycle (cnt == 99).
    task automatic window(input int nf);
        en = 1'b1;
        step(nf, 1);
        tick(99 - nf);
    endtask

    initial begin
        rst_n       = 1'b0;
        en          = 1'b0;
        en_sat      = 1'b0;
        delta_ready = 1'b0;
        ready_sat   = 1'b1;
        drive();
        tick(3);
        chk("rst_delta", 32'(delta), 32'h0);
        chk("rst_valid", 32'(delta_valid), 32'h0);
        chk("rst_overrun", 32'(overrun), 32'h0);
        rst_n = 1'b1;
        tick(2);

        // +10 in one window, consumed immediately
        delta_ready = 1'b1;
        window(10);
        chk("fwd10_preclose_valid", 32'(delta_valid), 32'h0);
        tick(1);
        chk("fwd10_valid", 32'(delta_valid), 32'h1);
        chk("fwd10_delta", 32'(delta), 32'h00A);
        tick(1);
        chk("fwd10_valid_drop", 32'(delta_valid), 32'h0);
        en = 1'b0;
        tick(2);

        // Saturation on the 512-cycle instance
        en_sat = 1'b1;
        step(300, 1);
        tick(211);
        chk("sat_pos_preclose_valid", 32'(valid_sat), 32'h0);
        tick(1);
        chk("sat_pos_valid", 32'(valid_sat), 32'h1);
        chk("sat_pos_delta", 32'(delta_sat), 32'h0FF);
        en_sat = 1'b0;
        tick(2);
        en_sat = 1'b1;
        step(300, -1);
        tick(212);
        chk("sat_neg_delta", 32'(delta_sat), 32'h100);
        en_sat = 1'b0;
        tick(2);

        // Overrun: +3 then -2 with ready low
        delta_ready = 1'b0;
        window(3);
        tick(1);
        chk("ovr_first_valid", 32'(delta_valid), 32'h1);
        chk("ovr_first_delta", 32'(delta), 32'h003);
        chk("ovr_first_flag", 32'(overrun), 32'h0);
        step(2, -1);
        tick(98);
        chk("ovr_second_delta", 32'(delta), 32'h1FE);
        chk("ovr_second_valid", 32'(delta_valid), 32'h1);
        chk("ovr_second_flag", 32'(overrun), 32'h1);
        en = 1'b0;
        delta_ready = 1'b1;
        tick(1);
        chk("ovr_ack_valid", 32'(delta_valid), 32'h0);
        chk("ovr_ack_flag", 32'(overrun), 32'h0);
        delta_ready = 1'b0;
        tick(1);

        // Close and handshake in the same cycle
        window(4);
        tick(1);
        chk("sim_first_valid", 32'(delta_valid), 32'h1);
        chk("sim_first_delta", 32'(delta), 32'h004);
        step(6, 1);
        tick(93);
        chk("sim_hold_delta", 32'(delta), 32'h004);
        delta_ready = 1'b1;
        tick(1);
        chk("sim_new_delta", 32'(delta), 32'h006);
        chk("sim_valid_kept", 32'(delta_valid), 32'h1);
        chk("sim_no_overrun", 32'(overrun), 32'h0);
        tick(1);
        chk("sim_valid_drop", 32'(delta_valid), 32'h0);
        en = 1'b0;
        delta_ready = 1'b0;
        tick(2);

        // Mid-window reset after 5 steps; encoder left at 00
        window(6);
        tick(1);
        chk("rstmid_pending_valid", 32'(delta_valid), 32'h1);
        step(5, 1);
        tick(45);
        rst_n = 1'b0;
        #1;
        chk("rstmid_delta", 32'(delta), 32'h0);
        chk("rstmid_valid", 32'(delta_valid), 32'h0);
        chk("rstmid_overrun", 32'(overrun), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(99);
        chk("rstmid_preclose_valid", 32'(delta_valid), 32'h0);
        tick(1);
        chk("rstmid_close_valid", 32'(delta_valid), 32'h1);
        chk("rstmid_close_delta", 32'(delta), 32'h0);
        en = 1'b0;
        delta_ready = 1'b1;
        tick(2);
        chk("rstmid_ack_valid", 32'(delta_valid), 32'h0);
`ifdef QUAD_ERR_EN
        chk("err_clear", 32'(enc_err), 32'h0);
`endif

        // Double-bit jumps contribute nothing: jump, +1, jump, +1 -> +2
        en = 1'b1;
        pos += 2;
        drive();
        tick(1);
        step(1, 1);
        pos += 2;
        drive();
        tick(1);
        step(1, 1);
        tick(95);
        tick(1);
        chk("jump_valid", 32'(delta_valid), 32'h1);
        chk("jump_delta", 32'(delta), 32'h002);
        en = 1'b0;
        tick(2);
`ifdef QUAD_ERR_EN
        chk("err_set", 32'(enc_err), 32'h1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
